// File: rtl/gate_arb_pkg.sv
// gate_arbiter shared types: opcodes, output state, gate function.
// Optional stats counter is enabled with GATE_ARB_STATS_EN.
package gate_arb_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } gate_op_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  localparam int GATE_WMAX = 64;

  function automatic int id_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [GATE_WMAX-1:0] gate_eval(
    gate_op_t               op,
    logic [GATE_WMAX-1:0]   a,
    logic [GATE_WMAX-1:0]   b
  );
    logic [GATE_WMAX-1:0] r;
    r = '0;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_arbiter_if.sv
// Requester and response bundle for gate_arbiter.
// slave = arbiter side, master = requesters plus consumer.
interface gate_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  import gate_arb_pkg::*;

  localparam int IW = id_w(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*2-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_y;
  logic [IW-1:0]     rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_y, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, req_op,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_y, rsp_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit at or above ptr, with wrap.
// Combinational; gnt is one-hot or zero.
module rr_arbiter
  import gate_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  int   j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_arbiter.sv
// Shared registered gate unit behind a round-robin arbiter.
// Define GATE_ARB_STATS_EN to add the saturating grant_cnt port.
module gate_arbiter
  import gate_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  gate_arbiter_if.slave  bus
`ifdef GATE_ARB_STATS_EN
  ,
  output logic [15:0]    grant_cnt
`endif
);

  localparam int IW = id_w(NREQ);

  out_state_t      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            can_accept;
  logic            take;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  gate_op_t        op_sel;
  logic [W-1:0]    y_q;
  logic [IW-1:0]   id_q;

  // rst_n gates the grant so nothing is offered while in reset
  assign can_accept = (state == EMPTY) | bus.rsp_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req  (bus.req_valid),
    .en   (can_accept & rst_n),
    .ptr  (ptr),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  assign take          = |gnt;
  assign bus.req_ready = gnt;

  assign a_sel  = bus.req_a[int'(gnt_idx)*W +: W];
  assign b_sel  = bus.req_b[int'(gnt_idx)*W +: W];
  assign op_sel = gate_op_t'(bus.req_op[int'(gnt_idx)*2 +: 2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      y_q   <= '0;
      id_q  <= '0;
      ptr   <= '0;
    end else if (take) begin
      state <= FULL;
      y_q   <= W'(gate_eval(op_sel,
                 GATE_WMAX'(a_sel),
                 GATE_WMAX'(b_sel)));
      id_q  <= gnt_idx;
      ptr   <= (int'(gnt_idx) == NREQ-1)
               ? '0 : gnt_idx + 1'b1;
    end else if (bus.rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_y     = y_q;
  assign bus.rsp_id    = id_q;

`ifdef GATE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (take && grant_cnt != 16'hFFFF) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    a_hold: assert property (
      @(posedge clk) disable iff (!rst_n)
      bus.req_valid[i] && !bus.req_ready[i]
      |=> bus.req_valid[i]
    );
  end
`endif

endmodule

// File: tb/tb_gate_arbiter.sv
// Bench for gate_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_gate_arbiter;
  import gate_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bit         m_full;
  logic [7:0] m_y;
  int         m_id;
  int         m_ptr;

  gate_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

`ifdef GATE_ARB_STATS_EN
  logic [15:0] grant_cnt;
`endif

  gate_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef GATE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_gate(
    int op, logic [7:0] a, logic [7:0] b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int exp_grant();
    int j;
    if (!rst_n) return -1;
    if (m_full && !bus.rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(int g);
    logic [3:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_full = 0;
    m_y    = '0;
    m_id   = 0;
    m_ptr  = 0;
  endtask

  task automatic set_lane(int i, logic [7:0] a,
                          logic [7:0] b, int op);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_op[i*2 +: 2] = 2'(op);
  endtask

  // Advance one clock, update model, drop valid of accepted requester.
  task automatic tick();
    int g;
    g = exp_grant();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (g >= 0) begin
      m_full = 1;
      m_y    = ref_gate(int'(bus.req_op[g*2 +: 2]),
                        bus.req_a[g*W +: W],
                        bus.req_b[g*W +: W]);
      m_id   = g;
      m_ptr  = (g + 1) % NREQ;
    end else if (bus.rsp_ready) begin
      m_full = 0;
    end
    @(negedge clk);
    if (g >= 0) bus.req_valid[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ready got %b want 0000", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_y !== 8'h00 || bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_data got %h/%0d want 00/0",
               bus.rsp_y, bus.rsp_id);
    end
    bus.req_valid = '0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_release got %b/%b want 0/0000",
               bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    set_lane(0, 8'hF0, 8'h3C, 0);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got %b want 0001", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 8'h30 ||
        bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL single_rsp got %b/%h/%0d want 1/30/0",
               bus.rsp_valid, bus.rsp_y, bus.rsp_id);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_y [4];
    exp_y = '{8'h0A, 8'hAF, 8'hA5, 8'hF5};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 8'hAA, 8'h0F, i);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== onehot(k)) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got %b want %b",
                 k, bus.req_ready, onehot(k));
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== exp_y[k] ||
          bus.rsp_id !== 2'(k)) begin
        errors++;
        $display("FAIL b2b_rsp[%0d] got %b/%h/%0d want 1/%h/%0d",
                 k, bus.rsp_valid, bus.rsp_y, bus.rsp_id,
                 exp_y[k], k);
      end
    end
  endtask

  task automatic test_hold();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL hold_ready[%0d] got %b want 0000",
                 c, bus.req_ready);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 8'hF5 ||
          bus.rsp_id !== 2'd3) begin
        errors++;
        $display("FAIL hold_rsp[%0d] got %b/%h/%0d want 1/f5/3",
                 c, bus.rsp_valid, bus.rsp_y, bus.rsp_id);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL hold_release got %b want 0100", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rsp_y !== 8'hA5 || bus.rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL hold_new got %h/%0d want a5/2",
               bus.rsp_y, bus.rsp_id);
    end
  endtask

  task automatic test_wrap();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_g3 got %b want 1000", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b1001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_g0 got %b want 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b1001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_next got %b want 1000", bus.req_ready);
    end
    tick();
    tick();
    checks++;
    if (bus.req_valid !== 4'b0000) begin
      errors++;
      $display("FAIL wrap_drain got %b want 0000", bus.req_valid);
    end
  endtask

  task automatic test_fairness();
    int cnt [4];
    cnt = '{0, 0, 0, 0};
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 3*NREQ; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i])
          set_lane(i, 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)));
      bus.req_valid = 4'b1111;
      tick();
      cnt[int'(bus.rsp_id)]++;
      checks++;
      if (bus.rsp_id !== 2'(c % NREQ)) begin
        errors++;
        $display("FAIL fair_id[%0d] got %0d want %0d",
                 c, bus.rsp_id, c % NREQ);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (cnt[i] != 3) begin
        errors++;
        $display("FAIL fair_cnt[%0d] got %0d want 3", i, cnt[i]);
      end
    end
    while (bus.req_valid != 0) tick();
  endtask

  task automatic test_random();
    logic [3:0] er;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_lane(i, 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)));
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = onehot(exp_grant());
      checks++;
      if (bus.req_ready !== er) begin
        errors++;
        $display("FAIL rnd_ready[%0d] got %b want %b",
                 c, bus.req_ready, er);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== m_full ||
          (m_full && (bus.rsp_y !== m_y ||
                      bus.rsp_id !== 2'(m_id)))) begin
        errors++;
        $display("FAIL rnd_rsp[%0d] got %b/%h/%0d want %b/%h/%0d",
                 c, bus.rsp_valid, bus.rsp_y, bus.rsp_id,
                 m_full, m_y, m_id);
      end
    end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 8 && bus.req_valid != 0; c++) tick();
    checks++;
    if (bus.req_valid !== 4'b0000) begin
      errors++;
      $display("FAIL rnd_drain got %b want 0000", bus.req_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    tick();
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst got %b/%b want 0/0000",
               bus.rsp_valid, bus.req_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_prio got %b want 0001", bus.req_ready);
    end
    for (int k = 0; k < NREQ; k++) begin
      tick();
      checks++;
      if (bus.rsp_id !== 2'(k) || bus.rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL mid_seq[%0d] got %b/%0d want 1/%0d",
                 k, bus.rsp_valid, bus.rsp_id, k);
      end
    end
  endtask

`ifdef GATE_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    checks++;
    if (grant_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_rst got %h want 0000", grant_cnt);
    end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = 4'b0001;
      tick();
    end
    checks++;
    if (grant_cnt !== 16'd5) begin
      errors++;
      $display("FAIL cnt_five got %h want 0005", grant_cnt);
    end
    force dut.grant_cnt = 16'hFFFE;
    #1;
    release dut.grant_cnt;
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 4'b0010;
      tick();
    end
    checks++;
    if (grant_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_sat got %h want ffff", grant_cnt);
    end
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_wrap();
    test_fairness();
    test_random();
    test_reset_mid();
`ifdef GATE_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
